// File: rtl/figure_cursor_fsm.sv
// rtl/figure_cursor_fsm.sv - cursor/selection state machine for the 3x3 figure display
module figure_cursor_fsm #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int CNT_W        = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       sel,
    output logic [8:0] fig_onehot,
    output logic       complete_screen,
    output logic [1:0] cursor_row,
    output logic [1:0] cursor_col
);

    typedef enum logic {
        BROWSE = 1'b0,
        FULL   = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    state_t           r_state;
    logic [1:0]       r_row;
    logic [1:0]       r_col;
    logic [8:0]       r_fig;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    dir_t             r_dir;
    logic [4:0]       r_prev;

    // button vector order: {sel, right, left, down, up}
    logic [4:0]       w_btn;
    logic [4:0]       w_edge;
    logic             w_held;
    dir_t             w_move;
    state_t           w_state_n;
    logic [1:0]       w_row_n;
    logic [1:0]       w_col_n;
    logic [8:0]       w_fig_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_phase_n;
    dir_t             w_dir_n;
    logic [3:0]       w_idx;

    assign w_btn  = {sel, right, left, down, up};
    assign w_edge = w_btn & ~r_prev;

    // Is the direction currently driving auto-repeat still pressed?
    always_comb begin
        w_held = 1'b0;
        case (r_dir)
            DIR_UP:    w_held = up;
            DIR_DOWN:  w_held = down;
            DIR_LEFT:  w_held = left;
            DIR_RIGHT: w_held = right;
            default:   w_held = 1'b0;
        endcase
    end

    // Next-state: mode toggle, edge-triggered moves, and auto-repeat timing
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_phase_n = r_phase;
        w_dir_n   = r_dir;
        w_move    = DIR_NONE;
        case (r_state)
            BROWSE: begin
                if (w_edge[4]) begin
                    // select wins; any simultaneous direction edge is dropped
                    w_state_n = FULL;
                    w_cnt_n   = '0;
                    w_phase_n = 1'b0;
                    w_dir_n   = DIR_NONE;
                end else if (w_edge[3:0] != 4'b0000) begin
                    if (w_edge[0])      w_move = DIR_UP;
                    else if (w_edge[1]) w_move = DIR_DOWN;
                    else if (w_edge[2]) w_move = DIR_LEFT;
                    else                w_move = DIR_RIGHT;
                    w_dir_n   = w_move;
                    w_cnt_n   = '0;
                    w_phase_n = 1'b0;
                end else if (r_dir != DIR_NONE) begin
                    if (!w_held) begin
                        w_cnt_n   = '0;
                        w_phase_n = 1'b0;
                        w_dir_n   = DIR_NONE;
                    end else if (r_cnt == (r_phase ? RATE_LAST : DELAY_LAST)) begin
                        w_move    = r_dir;
                        w_cnt_n   = '0;
                        w_phase_n = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                // repeat machinery stays idle while the figure is full-screen
                w_cnt_n   = '0;
                w_phase_n = 1'b0;
                w_dir_n   = DIR_NONE;
                if (w_edge[4]) begin
                    w_state_n = BROWSE;
                end
            end
            default: begin
                w_state_n = BROWSE;
            end
        endcase
    end

    // Cursor arithmetic with wrap-around, and the matching one-hot select
    always_comb begin
        w_row_n = r_row;
        w_col_n = r_col;
        case (w_move)
            DIR_UP:    w_row_n = (r_row == 2'd0) ? 2'd2 : r_row - 2'd1;
            DIR_DOWN:  w_row_n = (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
            DIR_LEFT:  w_col_n = (r_col == 2'd0) ? 2'd2 : r_col - 2'd1;
            DIR_RIGHT: w_col_n = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
            default: begin
                w_row_n = r_row;
                w_col_n = r_col;
            end
        endcase
        w_idx   = 4'(w_row_n) * 4'd3 + 4'(w_col_n);
        w_fig_n = 9'd1 << w_idx;
    end

    // State register; reset forces idle browse at the top-left figure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BROWSE;
            r_row   <= 2'd0;
            r_col   <= 2'd0;
            r_fig   <= 9'b000000001;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_dir   <= DIR_NONE;
            r_prev  <= 5'b11111;
        end else begin
            r_state <= w_state_n;
            r_row   <= w_row_n;
            r_col   <= w_col_n;
            r_fig   <= w_fig_n;
            r_cnt   <= w_cnt_n;
            r_phase <= w_phase_n;
            r_dir   <= w_dir_n;
            r_prev  <= w_btn;
        end
    end

    assign fig_onehot      = r_fig;
    assign complete_screen = (r_state == FULL);
    assign cursor_row      = r_row;
    assign cursor_col      = r_col;

endmodule
